// File: rtl/link_tx_scheduler.sv
// rtl/link_tx_scheduler.sv - two-producer arbiter and 6-bit chunk sequencer for the inter-board link
// Every link level is held for HOLD_CYCLES clocks so it clears the far-end debouncers.
module link_tx_scheduler #(
  parameter int MESSAGE_SIZE = 100,
  parameter int HOLD_CYCLES  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req,
  input  logic [MESSAGE_SIZE-1:0] msg0,
  input  logic [MESSAGE_SIZE-1:0] msg1,
  output logic [1:0]              grant,
  output logic [1:0]              done,
  output logic                    busy,
  output logic [5:0]              din_out,
  output logic                    packet_pulse,
  output logic                    transmit_ctrl
);

  localparam int NCHUNK = (MESSAGE_SIZE + 5) / 6;
  localparam int PAD_W  = 6 * NCHUNK;
  localparam int HW     = $clog2(HOLD_CYCLES + 1);
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(NCHUNK - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETUP, S_STROBE, S_COMMIT_HI, S_COMMIT_LO, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic                     w_q, w_d;
  logic                     rr_q, rr_d;
  logic [KW-1:0]            k_q, k_d;
  logic [HW-1:0]            hold_q, hold_d;
  logic [NCHUNK-1:0][5:0]   padded_q, padded_d;
  logic                     hold_end;

  always_comb begin
    state_d       = state_q;
    w_d           = w_q;
    rr_d          = rr_q;
    k_d           = k_q;
    hold_d        = hold_q;
    padded_d      = padded_q;
    grant         = 2'b00;
    done          = 2'b00;
    busy          = (state_q != S_IDLE);
    din_out       = 6'd0;
    packet_pulse  = 1'b0;
    transmit_ctrl = 1'b0;
    hold_end      = (hold_q == HOLD_LAST);

    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          // rr_q names the producer that gets a tie: the one not served last
          w_d     = (req == 2'b11) ? rr_q : req[1];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        grant    = w_q ? 2'b10 : 2'b01;
        padded_d = PAD_W'(w_q ? msg1 : msg0);
        k_d      = '0;
        hold_d   = '0;
        state_d  = S_SETUP;
      end
      S_SETUP: begin
        din_out = padded_q[k_q];
        if (hold_end) begin
          hold_d  = '0;
          state_d = S_STROBE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_STROBE: begin
        din_out      = padded_q[k_q];
        packet_pulse = 1'b1;
        if (hold_end) begin
          hold_d = '0;
          if (k_q == K_LAST) begin
            state_d = S_COMMIT_HI;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = S_SETUP;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_COMMIT_HI: begin
        transmit_ctrl = 1'b1;
        if (hold_end) begin
          hold_d  = '0;
          state_d = S_COMMIT_LO;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_COMMIT_LO: begin
        if (hold_end) begin
          hold_d  = '0;
          state_d = S_DONE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_DONE: begin
        done    = w_q ? 2'b10 : 2'b01;
        rr_d    = ~w_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      w_q      <= 1'b0;
      rr_q     <= 1'b0;
      k_q      <= '0;
      hold_q   <= '0;
      padded_q <= '0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      rr_q     <= rr_d;
      k_q      <= k_d;
      hold_q   <= hold_d;
      padded_q <= padded_d;
    end
  end

endmodule

// File: tb/tb_link_tx_scheduler.sv
// tb/tb_link_tx_scheduler.sv - bench for link_tx_scheduler against a per-cycle waveform model and a model receiver
module tb_link_tx_scheduler;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: defaults (HOLD_CYCLES=8); DUT B: HOLD_CYCLES=1
  logic        rst_a, rst_b;
  logic [1:0]  req_a, req_b;
  logic [99:0] msg0_a, msg1_a, msg0_b, msg1_b;
  logic [1:0]  grant_a, done_a, grant_b, done_b;
  logic        busy_a, pp_a, tc_a, busy_b, pp_b, tc_b;
  logic [5:0]  din_a, din_b;

  link_tx_scheduler u_dut_a (
    .clk(clk), .rst_n(rst_a), .req(req_a), .msg0(msg0_a), .msg1(msg1_a),
    .grant(grant_a), .done(done_a), .busy(busy_a), .din_out(din_a),
    .packet_pulse(pp_a), .transmit_ctrl(tc_a)
  );

  link_tx_scheduler #(.MESSAGE_SIZE(100), .HOLD_CYCLES(1)) u_dut_b (
    .clk(clk), .rst_n(rst_b), .req(req_b), .msg0(msg0_b), .msg1(msg1_b),
    .grant(grant_b), .done(done_b), .busy(busy_b), .din_out(din_b),
    .packet_pulse(pp_b), .transmit_ctrl(tc_b)
  );

  // bundle: {grant[1:0], done[1:0], busy, din[5:0], packet_pulse, transmit_ctrl}
  logic [12:0] obs_a, obs_b;
  assign obs_a = {grant_a, done_a, busy_a, din_a, pp_a, tc_a};
  assign obs_b = {grant_b, done_b, busy_b, din_b, pp_b, tc_b};

  int errors = 0;
  int checks = 0;

  // model far-end receiver per DUT
  logic [101:0] rx_buf [2];
  logic [99:0]  rx_com [2];
  logic [99:0]  last_com [2];
  logic         prev_pp [2];
  logic         prev_tc [2];

  int rr_a, rr_b;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [99:0] rand100();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[99:0];
  endfunction

  function automatic int winner(input logic [1:0] r, input int rr);
    if (r == 2'b11) return rr;
    return r[1] ? 1 : 0;
  endfunction

  // Expected outputs c cycles after LOAD, derived from the frame timeline.
  function automatic logic [12:0] exp_bundle(input int c, input int h, input int w, input logic [99:0] m);
    int n, len, j;
    logic [101:0] pad, sh;
    logic [1:0] oh;
    logic [12:0] e;
    n = 17;
    len = 2 + 2*n*h + 2*h;
    oh = (w == 1) ? 2'b10 : 2'b01;
    pad = {2'b00, m};
    e = '0;
    e[8] = 1'b1;
    if (c == 0) begin
      e[12:11] = oh;
    end else if (c <= 2*n*h) begin
      j = (c - 1) / (2*h);
      sh = pad >> (6*j);
      e[7:2] = sh[5:0];
      e[1] = (((c - 1) % (2*h)) >= h);
    end else if (c <= 2*n*h + h) begin
      e[0] = 1'b1;
    end
    if (c == len - 1) e[10:9] = oh;
    return e;
  endfunction

  task automatic sample(input int d, output logic [12:0] o);
    logic [101:0] b;
    o = (d == 0) ? obs_a : obs_b;
    chk($sformatf("excl d%0d", d), {127'd0, o[1] & o[0]}, 128'd0);
    if (o[1] && !prev_pp[d]) begin
      b = rx_buf[d];
      rx_buf[d] = {o[7:2], b[101:6]};
    end
    if (o[0] && !prev_tc[d]) begin
      b = rx_buf[d];
      rx_com[d] = b[99:0];
    end
    prev_pp[d] = o[1];
    prev_tc[d] = o[0];
  endtask

  task automatic idle_check(input int d, input string tag);
    logic [12:0] o;
    @(negedge clk);
    sample(d, o);
    chk(tag, {115'd0, o}, 128'd0);
  endtask

  // Steps through one frame from LOAD; abort_at >= 0 resets the DUT at that cycle.
  task automatic frame(input int d, input int w, input logic [99:0] m, input int abort_at, input bit keep);
    int h, len;
    logic [12:0] o;
    h = (d == 0) ? 8 : 1;
    len = 2 + 2*17*h + 2*h;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      sample(d, o);
      chk($sformatf("frame d%0d w%0d c%0d", d, w, c), {115'd0, o}, {115'd0, exp_bundle(c, h, w, m)});
      if (c == 1) begin
        if (d == 0) begin msg0_a = rand100(); msg1_a = rand100(); end
        else begin msg0_b = rand100(); msg1_b = rand100(); end
      end
      if (c == abort_at) begin
        if (d == 0) begin rst_a = 1'b0; req_a = 2'b00; end
        else begin rst_b = 1'b0; req_b = 2'b00; end
        idle_check(d, "abort_next_cycle");
        if (d == 0) rst_a = 1'b1; else rst_b = 1'b1;
        for (int i = 0; i < 4; i++) idle_check(d, "abort_no_done");
        chk("abort_rx_retained", {28'd0, rx_com[d]}, {28'd0, last_com[d]});
        return;
      end
      if (c == len - 1 && !keep) begin
        if (d == 0) req_a[w] = 1'b0; else req_b[w] = 1'b0;
      end
    end
    chk($sformatf("rx_commit d%0d", d), {28'd0, rx_com[d]}, {28'd0, m});
    last_com[d] = m;
  endtask

  initial begin
    int w;
    logic [12:0] o;
    logic [99:0] m;
    for (int i = 0; i < 2; i++) begin
      rx_buf[i] = '0; rx_com[i] = '0; last_com[i] = '0; prev_pp[i] = 1'b0; prev_tc[i] = 1'b0;
    end
    rst_a = 1'b0; rst_b = 1'b0;
    req_a = 2'b00; req_b = 2'b00;
    msg0_a = '0; msg1_a = '0; msg0_b = '0; msg1_b = '0;
    rr_a = 0; rr_b = 0;
    repeat (3) @(negedge clk);
    sample(0, o);
    chk("reset_a", {115'd0, o}, 128'd0);
    sample(1, o);
    chk("reset_b", {115'd0, o}, 128'd0);
    rst_a = 1'b1; rst_b = 1'b1;

    // single frame, chunk 0 = 3F
    msg0_a = 100'h3F;
    req_a = 2'b01;
    frame(0, 0, 100'h3F, -1, 1'b0);
    rr_a = 1;
    idle_check(0, "idle_after_single");

    // all ones: last chunk padded to 0F
    msg0_a = {100{1'b1}};
    req_a = 2'b01;
    frame(0, 0, {100{1'b1}}, -1, 1'b0);
    rr_a = 1;
    chk("rx_all_ones", {28'd0, rx_com[0]}, {28'd0, {100{1'b1}}});
    idle_check(0, "idle_after_ones");

    // arbitration from reset
    rst_a = 1'b0;
    idle_check(0, "arb_reset");
    rst_a = 1'b1;
    rr_a = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) req_a = 2'b11;
      else if (i == 2) req_a = 2'b11;
      else if (i < 6) req_a = req_a | 2'($urandom_range(0, 3));
      if (i < 6 && req_a == 2'b00) req_a = 2'b01;
      if (req_a == 2'b00) break;
      msg0_a = rand100(); msg1_a = rand100();
      w = winner(req_a, rr_a);
      m = (w == 1) ? msg1_a : msg0_a;
      frame(0, w, m, -1, 1'b0);
      rr_a = 1 - w;
      idle_check(0, "idle_after_arb");
    end

    // back-to-back: req kept high through the cycle after done
    msg0_a = rand100();
    m = msg0_a;
    req_a = 2'b01;
    frame(0, 0, m, -1, 1'b1);
    rr_a = 1;
    idle_check(0, "b2b_one_idle");
    m = msg0_a;
    frame(0, 0, m, -1, 1'b0);
    idle_check(0, "idle_after_b2b");

    // reset during chunk 8 STROBE
    msg1_a = rand100();
    m = msg1_a;
    req_a = 2'b10;
    frame(0, 1, m, 1 + 16*8 + 8, 1'b0);
    rr_a = 0;

    // recovery after the aborted frame
    msg0_a = rand100(); msg1_a = rand100();
    req_a = 2'b11;
    w = winner(req_a, rr_a);
    m = (w == 1) ? msg1_a : msg0_a;
    frame(0, w, m, -1, 1'b0);
    req_a = 2'b00;
    idle_check(0, "idle_after_recovery");

    // HOLD_CYCLES=1 instance: tie then the held request
    msg0_b = rand100(); msg1_b = rand100();
    req_b = 2'b11;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        msg0_b = rand100(); msg1_b = rand100();
        req_b = 2'b11;
      end
      w = winner(req_b, rr_b);
      m = (w == 1) ? msg1_b : msg0_b;
      frame(1, w, m, -1, 1'b0);
      rr_b = 1 - w;
      idle_check(1, "idle_b");
    end
    req_b = 2'b00;
    idle_check(1, "idle_b_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
